// File: rtl/jt6295_pkg.sv
// Shared constants and types for the JT6295 scheduler: sample dividers,
// slot boundary tables, timeout fill byte and the ROM arbiter state encoding.
package jt6295_pkg;

  localparam int unsigned DIV132 = 132;
  localparam int unsigned DIV165 = 165;

  localparam logic [7:0] LAST132 = 8'(DIV132 - 1);
  localparam logic [7:0] LAST165 = 8'(DIV165 - 1);

  // Index i holds the cen count at which slot i starts
  localparam logic [3:0][7:0] BND132 = {8'd99, 8'd66, 8'd33, 8'd0};
  localparam logic [3:0][7:0] BND165 = {8'd123, 8'd82, 8'd41, 8'd0};

  localparam logic [7:0] TOUT_VAL = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ADPCM = 2'd1,
    ST_RD_CTRL  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } bnd_t;

  function automatic bnd_t bnd_lookup(input logic [7:0] cnt, input logic ss_l);
    bnd_t r;
    r.hit = 1'b0;
    r.idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt == (ss_l ? BND132[i] : BND165[i])) begin
        r.hit = 1'b1;
        r.idx = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jt6295_sched_timer.sv
// Sample/slot timer: counts cen pulses per sample and emits the slot strobe
// (cen4), the sample strobe and the current slot number.
module jt6295_sched_timer
  import jt6295_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       ss,
  output logic       cen4,
  output logic       cen_sample,
  output logic [1:0] slot
);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] slot_q;
  logic       ss_l_q;
  logic       fresh_q;
  logic       ss_eff;
  logic       last;
  bnd_t       bnd;

  // Until the first cen after reset the rate follows ss directly
  assign ss_eff = fresh_q ? ss : ss_l_q;
  assign bnd    = bnd_lookup(cnt_q, ss_eff);
  assign last   = (cnt_q == (ss_eff ? LAST132 : LAST165));

  always_comb begin
    cnt_d = cnt_q;
    if (cen) begin
      cnt_d = last ? 8'd0 : cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      slot_q  <= 2'd0;
      ss_l_q  <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (fresh_q || (cen && last)) begin
        ss_l_q <= ss;
      end
      if (cen) begin
        fresh_q <= 1'b0;
      end
      if (cen && bnd.hit) begin
        slot_q <= bnd.idx;
      end
    end
  end

  assign cen4       = cen & ~rst & bnd.hit;
  assign cen_sample = cen & ~rst & (cnt_q == 8'd0);
  assign slot       = rst ? 2'd0 : ((cen & bnd.hit) ? bnd.idx : slot_q);

endmodule

// File: rtl/jt6295_sched.sv
// JT6295 scheduler top: slot/sample timer plus the single-port ROM arbiter
// (ADPCM fetches have priority over header/command reads).
// Optional watchdog on ROM reads: define JT6295_SCHED_TIMEOUT_EN.
module jt6295_sched
  import jt6295_pkg::*;
#(
  parameter int AW    = 18,
  parameter int OKLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          ss,
  output logic          cen4,
  output logic          cen_sample,
  output logic [1:0]    slot,
  input  logic          adpcm_req,
  input  logic [AW-1:0] adpcm_addr,
  output logic          adpcm_ack,
  input  logic          ctrl_req,
  input  logic [AW-1:0] ctrl_addr,
  output logic          ctrl_ack,
  output logic [7:0]    dout,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data
`ifdef JT6295_SCHED_TIMEOUT_EN
  ,
  output logic          rom_tout
`endif
);

  localparam logic [7:0] OKLAT_W = 8'(OKLAT);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cs_q, cs_d;
  logic [7:0]    dout_q, dout_d;
  logic          aack_q, aack_d;
  logic          cack_q, cack_d;
  logic [7:0]    w_q, w_d;
  logic          reading;
  logic          accept;
  logic          tout;
  logic          done;
  logic          ack_busy;

  jt6295_sched_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .ss         (ss),
    .cen4       (cen4),
    .cen_sample (cen_sample),
    .slot       (slot)
  );

  // w starts at 0 in the first cs cycle, so an ok left over from the
  // previous access is ignored until OKLAT cycles have passed
  assign reading  = (state_q == ST_RD_ADPCM) || (state_q == ST_RD_CTRL);
  assign accept   = reading && rom_ok && (w_q >= OKLAT_W);
  assign done     = accept || tout;
  assign ack_busy = aack_q || cack_q;

`ifdef JT6295_SCHED_TIMEOUT_EN
  logic tout_q;

  assign tout     = reading && !accept && (w_q == 8'd254);
  assign rom_tout = tout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_q <= 1'b0;
    end else if (tout) begin
      tout_q <= 1'b1;
    end else begin
      tout_q <= tout_q;
    end
  end
`else
  assign tout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // No grant while an ack is visible: the requester gets one cycle to drop req
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!ack_busy && adpcm_req) begin
          state_d = ST_RD_ADPCM;
        end else if (!ack_busy && ctrl_req) begin
          state_d = ST_RD_CTRL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADPCM, ST_RD_CTRL: begin
        if (done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cs_d   = cs_q;
    dout_d = dout_q;
    aack_d = 1'b0;
    cack_d = 1'b0;
    w_d    = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RD_ADPCM) begin
          addr_d = adpcm_addr;
          cs_d   = 1'b1;
        end else if (state_d == ST_RD_CTRL) begin
          addr_d = ctrl_addr;
          cs_d   = 1'b1;
        end else begin
          cs_d   = 1'b0;
        end
      end
      ST_RD_ADPCM, ST_RD_CTRL: begin
        if (done) begin
          cs_d   = 1'b0;
          dout_d = accept ? rom_data : TOUT_VAL;
          aack_d = (state_q == ST_RD_ADPCM);
          cack_d = (state_q == ST_RD_CTRL);
        end else begin
          w_d    = (w_q == 8'hFF) ? w_q : w_q + 8'd1;
        end
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cs_q   <= 1'b0;
      dout_q <= 8'd0;
      aack_q <= 1'b0;
      cack_q <= 1'b0;
      w_q    <= 8'd0;
    end else begin
      addr_q <= addr_d;
      cs_q   <= cs_d;
      dout_q <= dout_d;
      aack_q <= aack_d;
      cack_q <= cack_d;
      w_q    <= w_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_cs    = cs_q;
  assign dout      = dout_q;
  assign adpcm_ack = aack_q;
  assign ctrl_ack  = cack_q;

endmodule

// File: tb/tb_jt6295_sched.sv
// Bench for jt6295_sched: per-cycle timing/arbitration model checks plus
// directed rate, arbitration, stale-ok, reset and (optional) timeout cases.
`timescale 1ns/1ps
module tb_jt6295_sched;

  localparam int AW    = 18;
  localparam int OKLAT = 1;

  logic          clk = 1'b0;
  logic          rst, cen, ss;
  logic          cen4, cen_sample;
  logic [1:0]    slot;
  logic          adpcm_req, ctrl_req, adpcm_ack, ctrl_ack;
  logic [AW-1:0] adpcm_addr, ctrl_addr, rom_addr;
  logic [7:0]    dout, rom_data;
  logic          rom_cs, rom_ok;
`ifdef JT6295_SCHED_TIMEOUT_EN
  logic          rom_tout;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_acks = 0;

  jt6295_sched #(.AW(AW), .OKLAT(OKLAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .ss         (ss),
    .cen4       (cen4),
    .cen_sample (cen_sample),
    .slot       (slot),
    .adpcm_req  (adpcm_req),
    .adpcm_addr (adpcm_addr),
    .adpcm_ack  (adpcm_ack),
    .ctrl_req   (ctrl_req),
    .ctrl_addr  (ctrl_addr),
    .ctrl_ack   (ctrl_ack),
    .dout       (dout),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data)
`ifdef JT6295_SCHED_TIMEOUT_EN
    ,
    .rom_tout   (rom_tout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // cen: one clk in eight
  int cen_ph = 0;
  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk); #1;
      cen_ph = (cen_ph + 1) % 8;
      cen    = (cen_ph == 0);
    end
  end

  // ROM: mode 0 = ok after 3 cs cycles, 1 = ok always high, 2 = never ok
  function automatic logic [7:0] rom_mem(input logic [AW-1:0] a);
    case (a)
      18'h00100: rom_mem = 8'h5A;
      18'h00008: rom_mem = 8'hC3;
      default:   rom_mem = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  assign rom_data = rom_mem(rom_addr);

  int rom_mode = 0;
  int rom_age  = 0;
  initial begin
    rom_ok = 1'b0;
    forever begin
      @(posedge clk); #1;
      rom_age = (rom_cs === 1'b1) ? rom_age + 1 : 0;
      case (rom_mode)
        0:       rom_ok = (rom_age >= 3);
        1:       rom_ok = 1'b1;
        default: rom_ok = 1'b0;
      endcase
    end
  end

  // Per-cycle model: sample period P from the rate, slot k starts at k*(P/4)
  int            m_cnt = 0, m_p = 132, m_slot = 0;
  bit            m_fresh = 1'b1;
  bit            p_cs = 1'b0, p_areq = 1'b0, p_creq = 1'b0;
  logic [AW-1:0] p_aaddr, p_caddr, cur_addr;
  bit            cur_adpcm = 1'b0;
  int            cs_cyc = 0;
  bit            ok_seen = 1'b0;

  always @(negedge clk) begin : cmp
    int         q;
    bit         hit;
    logic [7:0] exp_d;
    if (rst === 1'b1) begin
      chk("rst_cen4", cen4, 0);
      chk("rst_cen_sample", cen_sample, 0);
      chk("rst_slot", slot, 0);
      chk("rst_rom_cs", rom_cs, 0);
      chk("rst_acks", {adpcm_ack, ctrl_ack}, 0);
      chk("rst_dout", dout, 0);
      m_cnt = 0; m_slot = 0; m_fresh = 1'b1; m_p = ss ? 132 : 165;
      cs_cyc = 0; ok_seen = 1'b0;
    end else begin
      if (m_fresh) m_p = ss ? 132 : 165;
      q   = m_p / 4;
      hit = cen && (m_cnt % q == 0) && (m_cnt / q < 4);
      chk("cen4", cen4, hit);
      chk("cen_sample", cen_sample, cen && (m_cnt == 0));
      chk("slot", slot, hit ? m_cnt / q : m_slot);
      if (hit) m_slot = m_cnt / q;
      if (cen) begin
        m_fresh = 1'b0;
        m_cnt++;
        if (m_cnt == m_p) begin
          m_cnt = 0;
          m_p   = ss ? 132 : 165;
        end
      end
      if (rom_cs === 1'b1) begin
        if (!p_cs) begin
          chk("grant_has_req", p_areq | p_creq, 1);
          cur_adpcm = p_areq;
          cur_addr  = p_areq ? p_aaddr : p_caddr;
          chk("grant_addr", rom_addr, cur_addr);
          cs_cyc  = 0;
          ok_seen = 1'b0;
        end else begin
          chk("addr_hold", rom_addr, cur_addr);
        end
        if (rom_ok && cs_cyc >= OKLAT) ok_seen = 1'b1;
        cs_cyc++;
      end
      if (adpcm_ack || ctrl_ack) begin
        n_acks++;
        chk("ack_excl", adpcm_ack & ctrl_ack, 0);
        chk("ack_cs_low", rom_cs, 0);
        chk("ack_after_access", p_cs, 1);
        chk("ack_owner", adpcm_ack, cur_adpcm);
        if (cs_cyc >= 255) begin
          exp_d = 8'h80;
        end else begin
          exp_d = rom_mem(cur_addr);
          chk("ack_ok_seen", ok_seen, 1);
        end
        chk("ack_dout", dout, exp_d);
      end
    end
    p_cs    = (rom_cs === 1'b1) && (rst !== 1'b1);
    p_areq  = adpcm_req;
    p_creq  = ctrl_req;
    p_aaddr = adpcm_addr;
    p_caddr = ctrl_addr;
  end

  // Measure one sample from cen_sample to the next using DUT outputs only
  task automatic meas_sample(input int exp_p, input int b1, input int b2, input int b3,
                             input bit chg);
    int pos, nb, guard;
    int bp[4];
    int bs[4];
    guard = 0;
    while (cen_sample !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("sample_sync", cen_sample, 1);
    if (cen_sample !== 1'b1) return;
    chk("sample_with_cen4", cen4, 1);
    bp = '{0, -1, -1, -1};
    bs = '{0, 0, 0, 0};
    bs[0] = int'(slot);
    pos = 0; nb = 1; guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        chk("sample_end_timeout", 0, 1);
        return;
      end
      if (cen === 1'b1) begin
        pos++;
        if (cen_sample === 1'b1) break;
        if (cen4 === 1'b1) begin
          if (nb < 4) begin
            bp[nb] = pos;
            bs[nb] = int'(slot);
          end
          nb++;
        end
        if (chg && pos == 50) begin
          @(posedge clk); #1;
          ss = 1'b0;
        end
      end
    end
    chk("period", pos, exp_p);
    chk("slot_strobes", nb, 4);
    chk("bnd1", bp[1], b1);
    chk("bnd2", bp[2], b2);
    chk("bnd3", bp[3], b3);
    for (int k = 0; k < 4; k++) chk("bnd_slot", bs[k], k);
  endtask

  // Raise the requested reqs together; each drops the cycle after its ack
  task automatic run_req(input bit do_a, input bit do_c,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ca, input int max_c,
                         output int t_a, output int t_c,
                         output logic [7:0] d_a, output logic [7:0] d_c, output int gap);
    bit drop_a, drop_c;
    t_a = -1; t_c = -1; d_a = 8'd0; d_c = 8'd0; gap = 0;
    @(posedge clk); #1;
    adpcm_addr = aa; ctrl_addr = ca;
    adpcm_req  = do_a; ctrl_req = do_c;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      drop_a = adpcm_ack;
      drop_c = ctrl_ack;
      if (adpcm_ack === 1'b1) begin t_a = c; d_a = dout; end
      if (ctrl_ack === 1'b1)  begin t_c = c; d_c = dout; end
      if (t_a >= 0 && t_c < 0 && rom_cs === 1'b0) gap++;
      if ((!do_a || t_a >= 0) && (!do_c || t_c >= 0)) break;
      @(posedge clk); #1;
      if (drop_a) adpcm_req = 1'b0;
      if (drop_c) ctrl_req  = 1'b0;
    end
    @(posedge clk); #1;
    adpcm_req = 1'b0;
    ctrl_req  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin : stim
    int         ta, tc, gap, guard, acks_before;
    logic [7:0] da, dc;
    rst = 1'b1; ss = 1'b1;
    adpcm_req = 1'b0; ctrl_req = 1'b0;
    adpcm_addr = '0; ctrl_addr = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef JT6295_SCHED_TIMEOUT_EN
    chk("tout_after_reset", rom_tout, 0);
`endif

    // Rate 132, then a switch to 165 requested mid-sample at count 50
    meas_sample(132, 33, 66, 99, 1'b0);
    meas_sample(132, 33, 66, 99, 1'b1);
    meas_sample(165, 41, 82, 123, 1'b0);

    // Simultaneous requests: ADPCM first, ctrl one access later
    rom_mode = 0;
    run_req(1'b1, 1'b1, 18'h00100, 18'h00008, 40, ta, tc, da, dc, gap);
    chk("simul_adpcm_ack_cycle", ta, 4);
    chk("simul_adpcm_dout", da, 8'h5A);
    chk("simul_ctrl_ack_cycle", tc, 9);
    chk("simul_ctrl_dout", dc, 8'hC3);
    chk("simul_cs_gap", (gap >= 1) ? 1 : 0, 1);

    // Stale ok: ok already high when cs rises must be ignored in that cycle
    rom_mode = 1;
    run_req(1'b1, 1'b0, 18'h00200, 18'h00000, 20, ta, tc, da, dc, gap);
    chk("stale_ack_cycle", ta, 3);
    chk("stale_dout", da, 8'h3C);
    rom_mode = 0;

`ifdef JT6295_SCHED_TIMEOUT_EN
    rom_mode = 2;
    run_req(1'b1, 1'b0, 18'h00300, 18'h00000, 300, ta, tc, da, dc, gap);
    chk("tout_ack_cycle", ta, 256);
    chk("tout_dout", da, 8'h80);
    chk("tout_flag", rom_tout, 1);
    rom_mode = 0;
    run_req(1'b0, 1'b1, 18'h00000, 18'h00008, 40, ta, tc, da, dc, gap);
    chk("post_tout_ctrl_dout", dc, 8'hC3);
    chk("tout_sticky", rom_tout, 1);
`endif

    // Reset in the middle of a ctrl read
    rom_mode = 2;
    @(posedge clk); #1;
    ctrl_addr = 18'h00008;
    ctrl_req  = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rd_cs", rom_cs, 1);
    acks_before = n_acks;
    @(posedge clk); #1;
    rst = 1'b1;
    ctrl_req = 1'b0;
    #1;
    chk("rst_now_cs", rom_cs, 0);
    chk("rst_now_acks", {adpcm_ack, ctrl_ack}, 0);
    chk("rst_now_cen4", cen4, 0);
    chk("rst_now_slot", slot, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rom_mode = 0;
    guard = 0;
    while (cen !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("first_cen_seen", cen, 1);
    chk("first_cen4", cen4, 1);
    chk("first_cen_sample", cen_sample, 1);
    chk("first_slot", slot, 0);
    chk("no_ack_after_reset", n_acks, acks_before);
`ifdef JT6295_SCHED_TIMEOUT_EN
    chk("tout_cleared", rom_tout, 0);
`endif
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt6295_sched.md
Name: jt6295_sched

Overview:
- Timing and ROM-access controller for the JT6295 core.
- Derives the per-channel slot strobe (cen4) and the sample strobe from the chip clock enable. These strobes sequence the 4-channel ADPCM engine and the output accumulator/upsampler.
- Arbitrates the single external ROM port between the ADPCM nibble fetcher and the command/header reader.

Parameters:
- AW, 18, ROM byte-address width
- OKLAT, 1, minimum clk cycles after rom_cs rises before rom_ok is trusted (discards a stale ok)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  chip clock enable (nominal 1 MHz)
- ss  in  1  sample-rate select: 1 = divide by 132, 0 = divide by 165
- cen4  out  1  slot strobe, one clk wide, on a cen cycle
- cen_sample  out  1  sample strobe, one clk wide, always coincident with the slot-0 cen4
- slot  out  2  current channel slot 0..3
- adpcm_req  in  1  ADPCM fetch request, level, held until ack
- adpcm_addr  in  AW  ADPCM fetch address
- adpcm_ack  out  1  one-clk pulse, data valid
- ctrl_req  in  1  header/command fetch request, level
- ctrl_addr  in  AW  header/command fetch address
- ctrl_ack  out  1  one-clk pulse, data valid
- dout  out  8  fetched byte, shared by both requesters
- rom_addr  out  AW  ROM address
- rom_cs  out  1  ROM chip select
- rom_ok  in  1  ROM data valid
- rom_data  in  8  ROM data

Behaviour:
- Reset: all outputs 0. Counter and slot are 0, FSM is IDLE, ss_l = ss.
- Cycle counter:
  - Counts cen pulses 0..P-1, where P = 132 if ss_l else 165.
  - ss_l is re-sampled only when the counter wraps to 0, so a rate change never splits a sample.
- Slot boundaries:
  - P=132: counts 0, 33, 66, 99.
  - P=165: counts 0, 41, 82, 123, so the last slot is 42 long.
- At each boundary: cen4 pulses in that clk, slot updates in the same cycle (combinational from the boundary), registered thereafter.
- At count 0: cen_sample pulses together with cen4.
- cen4 and cen_sample are never asserted when cen=0.
- Arbiter FSM:
  - States: IDLE, RD_ADPCM, RD_CTRL.
  - IDLE:
    - If adpcm_req, latch adpcm_addr into rom_addr, set rom_cs=1, go to RD_ADPCM.
    - Else if ctrl_req, the same with ctrl_addr, go to RD_CTRL.
    - Simultaneous requests: ADPCM wins.
  - RD_x:
    - Hold rom_addr and rom_cs; wait counter w increments each clk.
    - rom_ok is accepted only once w >= OKLAT.
    - On accept: dout <= rom_data, pulse x_ack for one clk, clear rom_cs, go to IDLE.
  - Back-to-back reads: ack cycle → IDLE → next grant. rom_cs is low for at least 1 clk between accesses.
  - Starvation bound: the requester must drop req in the cycle after ack or be re-served. Fixed priority is acceptable because the ADPCM side issues at most one fetch per slot, so ctrl waits at most one access.
- A requester dropping req before its grant is simply withdrawn. Dropping req after grant has no effect; the read completes and is acked.
- Slot timing and arbitration are independent; a ROM access may span a slot boundary.
- Reset mid-access: rom_cs drops immediately, no ack is issued, FSM returns to IDLE.

Optional Feature:
- Macro: JT6295_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts clks in RD_x.
  - At 255 without an accepted rom_ok: abort, dout <= 8'h80 (ADPCM zero-step nibble pair), pulse x_ack, rom_cs=0, go to IDLE.
  - The sticky output port rom_tout (1 bit, cleared only by rst) is set.
- Undefined: no watchdog and no rom_tout port; the FSM waits indefinitely.

Decomposition:
- Shared package jt6295_pkg:
  - Constants: DIV132=132, DIV165=165, slot boundary tables, TOUT_VAL=8'h80.
  - FSM state encoding.
- One natural sub-module: jt6295_sched_timer, which contains the cycle counter, ss_l, slot and cen4/cen_sample. The arbiter FSM stays in the top module.

Test Plan:
- Rate 132: cen every 8 clk, ss=1.
  - cen4 is seen at cen counts 0, 33, 66, 99 with slot 0, 1, 2, 3.
  - cen_sample occurs every 132 cen pulses, only together with slot-0 cen4.
- Rate change: ss=0 mid-sample at count 50.
  - The current sample still ends at 132.
  - The next sample has boundaries 0, 41, 82, 123 and a period of 165.
- Simultaneous requests: adpcm_req and ctrl_req rise together (adpcm_addr=0x00100, ctrl_addr=0x00008); ROM returns 0x5A then 0xC3 with rom_ok 3 clk after cs.
  - adpcm_ack comes first with dout=0x5A.
  - Then ctrl_ack with dout=0xC3.
  - rom_cs is low for at least 1 clk between the two accesses.
- Stale ok: rom_ok is held high when cs rises, OKLAT=1.
  - Data is not accepted in the first cs cycle; ack comes at the first cycle where w >= 1.
- Reset mid-access: rst asserted during RD_CTRL.
  - rom_cs, acks, cen4 and slot go to 0 immediately.
  - After release, the first cen4 occurs on the first cen.
- Timeout (TIMEOUT_EN): rom_ok never asserted for adpcm_req.
  - adpcm_ack is seen 255 clk after the grant with dout=0x80.
  - rom_tout=1 and stays set until rst.
